// File: rtl/timing_pkg.sv
// Timing-recovery NCO shared definitions: default widths, typedefs,
// samples-per-symbol helpers and the nominal step W0.
package timing_pkg;

  localparam int NCO_W_DEF    = 24;
  localparam int CTRL_W_DEF   = 16;
  localparam int MU_W_DEF     = 16;
  localparam int SPS_DEF      = 2;
  localparam int CTRL_LIM_DEF = 'h100;

  typedef logic [NCO_W_DEF-1:0]         nco_phase_t;
  typedef logic [MU_W_DEF-1:0]          mu_t;
  typedef logic signed [CTRL_W_DEF-1:0] ctrl_t;

  function automatic int log2_sps(input int sps);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((32'sd1 << i) < sps) r = i + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Nominal decrement per sample for the default configuration.
  localparam nco_phase_t W0_DEF =
    nco_phase_t'(1) << (NCO_W_DEF - log2_sps(SPS_DEF));

endpackage

// File: rtl/timing_nco_step.sv
// Step generator: optional ctrl clamp, W = W0 + sext(ctrl), W saturated.
// Ports: ctrl (signed held word) in; w (step), sat (ctrl clamped) out.
// Clamp enabled by macro TNCO_CTRL_LIMIT_EN; otherwise sat is 0.
module timing_nco_step
  import timing_pkg::*;
#(
  parameter int NCO_W    = NCO_W_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int SPS      = SPS_DEF,
  parameter int CTRL_LIM = CTRL_LIM_DEF
) (
  input  logic signed [CTRL_W-1:0] ctrl,
  output logic        [NCO_W-1:0]  w,
  output logic                     sat
);

  localparam int LG = log2_sps(SPS);
  // Two guard bits so the signed sum can never wrap.
  localparam int XW = NCO_W + 2;

  localparam logic signed [XW-1:0] ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] W0X  = ONE << (NCO_W - LG);
  localparam logic signed [XW-1:0] WMAX = (ONE << NCO_W) - ONE;

  if (CTRL_LIM <= 0 || CTRL_LIM >= (32'sd1 << (CTRL_W - 1))) begin : g_bad_lim
    $error("CTRL_LIM must be in [1, 2^(CTRL_W-1)-1]");
  end

  logic signed [CTRL_W-1:0] c;
  logic signed [XW-1:0]     cx;
  logic signed [XW-1:0]     wx;

`ifdef TNCO_CTRL_LIMIT_EN
  localparam logic signed [CTRL_W-1:0] LIM_P = CTRL_W'(CTRL_LIM);
  localparam logic signed [CTRL_W-1:0] LIM_N = -LIM_P;

  always_comb begin
    c   = ctrl;
    sat = 1'b0;
    if (ctrl > LIM_P) begin
      c   = LIM_P;
      sat = 1'b1;
    end else if (ctrl < LIM_N) begin
      c   = LIM_N;
      sat = 1'b1;
    end
  end
`else
  assign c   = ctrl;
  assign sat = 1'b0;
`endif

  assign cx = {{(XW-CTRL_W){c[CTRL_W-1]}}, c};
  assign wx = W0X + cx;

  // A zero or negative step would stall the NCO; clip to [1, 2^NCO_W-1].
  always_comb begin
    if (wx[XW-1] || wx == '0)
      w = NCO_W'(1);
    else if (wx > WMAX)
      w = WMAX[NCO_W-1:0];
    else
      w = wx[NCO_W-1:0];
  end

endmodule

// File: rtl/timing_nco.sv
// Timing-recovery NCO: decrementing phase register, borrow = symbol strobe.
// Ports: clk, reset, in_valid, ctrl, ctrl_valid in; out_valid, strobe,
// mu, sym_cnt, ctrl_sat out. Optional clamp macro: TNCO_CTRL_LIMIT_EN.
module timing_nco
  import timing_pkg::*;
#(
  parameter int NCO_W    = NCO_W_DEF,
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int MU_W     = MU_W_DEF,
  parameter int SPS      = SPS_DEF,
  parameter int CTRL_LIM = CTRL_LIM_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [CTRL_W-1:0] ctrl,
  input  logic                     ctrl_valid,
  output logic                     out_valid,
  output logic                     strobe,
  output logic        [MU_W-1:0]   mu,
  output logic        [15:0]       sym_cnt,
  output logic                     ctrl_sat
);

  localparam int LG = log2_sps(SPS);

  if (!is_pow2(SPS) || SPS < 2) begin : g_bad_sps
    $error("SPS must be a power of two >= 2");
  end
  if (MU_W > NCO_W) begin : g_bad_mu
    $error("MU_W must not exceed NCO_W");
  end
  if (CTRL_W >= NCO_W) begin : g_bad_ctrl
    $error("CTRL_W must be less than NCO_W");
  end

  logic        [NCO_W-1:0]  eta;
  logic signed [CTRL_W-1:0] ctrl_q;
  logic        [NCO_W-1:0]  w;
  logic                     sat;
  logic                     hit;

  timing_nco_step #(
    .NCO_W    (NCO_W),
    .CTRL_W   (CTRL_W),
    .SPS      (SPS),
    .CTRL_LIM (CTRL_LIM)
  ) u_step (
    .ctrl (ctrl_q),
    .w    (w),
    .sat  (sat)
  );

  // Borrow on the coming decrement marks the symbol boundary.
  assign hit = eta < w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eta       <= '0;
      ctrl_q    <= '0;
      out_valid <= 1'b0;
      strobe    <= 1'b0;
      mu        <= '0;
      sym_cnt   <= '0;
      ctrl_sat  <= 1'b0;
    end else begin
      // Sample in the same cycle still sees the old ctrl_q.
      if (ctrl_valid)
        ctrl_q <= ctrl;
      out_valid <= in_valid;
      strobe    <= in_valid & hit;
      ctrl_sat  <= in_valid & sat;
      if (in_valid) begin
        eta <= eta - w;
        if (hit) begin
          // eta/W ~ eta*SPS/2^NCO_W; keep the top MU_W bits.
          mu      <= MU_W'((eta << LG) >> (NCO_W - MU_W));
          sym_cnt <= sym_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_nco.sv
// Self-checking bench for timing_nco: vector table, scoreboard model,
// reset mid-run and ctrl clamp/saturation sequences.
module tb_timing_nco;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] ctrl;
  logic               ctrl_valid;
  logic               out_valid;
  logic               strobe;
  logic        [15:0] mu;
  logic        [15:0] sym_cnt;
  logic               ctrl_sat;

  always #5 clk = ~clk;

  timing_nco dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .out_valid  (out_valid),
    .strobe     (strobe),
    .mu         (mu),
    .sym_cnt    (sym_cnt),
    .ctrl_sat   (ctrl_sat)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          ov;
    bit          st;
    logic [15:0] mu;
    logic [15:0] sc;
    bit          sat;
  } exp_t;

  typedef struct {
    bit          iv;
    bit          cv;
    int          c;
    bit          st;
    logic [15:0] mu;
  } vec_t;

  exp_t q[$];

  longint      m_eta;
  longint      m_ctrl;
  logic [15:0] m_mu;
  logic [15:0] m_sc;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_eta  = 0;
    m_ctrl = 0;
    m_mu   = '0;
    m_sc   = '0;
    q.delete();
  endtask

  // Drive one cycle at negedge, predict, then compare after posedge.
  task automatic step(input bit iv, input bit cv, input int c);
    exp_t   e;
    exp_t   g;
    longint w;
    bit     s;
    @(negedge clk);
    in_valid   = iv;
    ctrl_valid = cv;
    ctrl       = c[15:0];
    e.ov  = iv;
    e.st  = 1'b0;
    e.sat = 1'b0;
    if (iv) begin
      w = m_ctrl;
      s = 1'b0;
`ifdef TNCO_CTRL_LIMIT_EN
      if (w > 256) begin
        w = 256;
        s = 1'b1;
      end else if (w < -256) begin
        w = -256;
        s = 1'b1;
      end
`endif
      w = 64'sd8388608 + w;
      if (w < 1) w = 1;
      if (w > 64'sd16777215) w = 64'sd16777215;
      if (m_eta < w) begin
        e.st = 1'b1;
        m_mu = 16'(((m_eta * 2) % 16777216) / 256);
        m_sc = m_sc + 16'd1;
      end
      m_eta = (m_eta - w + 16777216) % 16777216;
      e.sat = s;
    end
    if (cv) m_ctrl = c;
    e.mu = m_mu;
    e.sc = m_sc;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    check("out_valid", out_valid, g.ov);
    check("strobe", strobe, g.st);
    check("mu", mu, g.mu);
    check("sym_cnt", sym_cnt, g.sc);
    check("ctrl_sat", ctrl_sat, g.sat);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_st"}, strobe, 0);
    check({tag, "_mu"}, mu, 0);
    check({tag, "_sc"}, sym_cnt, 0);
    check({tag, "_sat"}, ctrl_sat, 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl = '{
      '{1, 0, 0,       1, 16'h0000},
      '{1, 0, 0,       0, 16'h0000},
      '{1, 0, 0,       1, 16'h0000},
      '{1, 0, 0,       0, 16'h0000},
      '{0, 1, -'h1000, 0, 16'h0000},
      '{1, 0, 0,       1, 16'h0000},
      '{1, 0, 0,       0, 16'h0000},
      '{1, 0, 0,       1, 16'h0040}
    };

    reset      = 1'b0;
    in_valid   = 1'b0;
    ctrl_valid = 1'b0;
    ctrl       = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].iv, tbl[i].cv, tbl[i].c);
`ifndef TNCO_CTRL_LIMIT_EN
      check($sformatf("tbl%0d_st", i), strobe, tbl[i].st);
      check($sformatf("tbl%0d_mu", i), mu, tbl[i].mu);
`endif
    end
`ifndef TNCO_CTRL_LIMIT_EN
    check("eta_after_tbl", dut.eta, 32'h803000);
`endif

    // Gapped input: bench model indexes only valid samples.
    for (int k = 0; k < 30; k++) begin
      step(1, 0, 0);
      repeat ($urandom_range(0, 3)) step(0, 0, 0);
    end

    // Asynchronous reset mid-cycle, with a sample in flight.
    @(negedge clk);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_hold");
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    model_reset();

    step(0, 1, 'h1000);
    step(1, 0, 0);
    check("rst_first_st", strobe, 1);
    check("rst_first_sc", sym_cnt, 1);
    step(1, 0, 0);
`ifndef TNCO_CTRL_LIMIT_EN
    check("pos_ctrl_mu", mu, 16'hFFE0);
    check("pos_ctrl_st", strobe, 1);
`endif
    repeat (6) step(1, 0, 0);

    step(0, 1, 'h7FFF);
    #1;
`ifdef TNCO_CTRL_LIMIT_EN
    check("w_lim", dut.w, 32'h800100);
`else
    check("w_nolim", dut.w, 32'h807FFF);
`endif
    repeat (6) step(1, 0, 0);

    step(0, 1, -'h8000);
    repeat (6) step(1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
